// File: rtl/sc_pkg.sv
// Shared constants and state encoding for the stochastic-to-binary converter.
// The N/POW2N/saturation values describe the default 12-bit configuration.
package sc_pkg;

    localparam int N     = 12;
    localparam int POW2N = 1 << N;

    // Bipolar saturation limits for the default N: +4095 and -4096 (0x1000).
    localparam logic signed [N:0] BIP_SAT_MAX = (N+1)'(POW2N - 1);
    localparam logic signed [N:0] BIP_SAT_MIN = (N+1)'(POW2N);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/sc_bit_counter.sv
// Window counters: total accepted bits (seen) and accepted ones (ones).
// terminal flags the accepted bit that brings seen up to 2^N.
module sc_bit_counter #(
    parameter int N = 12
) (
    input  logic         clock_s,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         bit_in,
    output logic [N:0]   ones,
    output logic         terminal
);

    localparam logic [N:0] LAST_SEEN = (N+1)'((1 << N) - 1);

    logic [N:0] seen;

    assign terminal = enable && (seen == LAST_SEEN);

    always_ff @(posedge clock_s) begin
        if (reset || clear) begin
            seen <= '0;
            ones <= '0;
        end else if (enable) begin
            seen <= seen + (N+1)'(1);
            ones <= ones + (N+1)'(bit_in);
        end
    end

endmodule

// File: rtl/sc_to_bin.sv
// Converts a 2^N-bit stochastic bitstream into an N+1 bit binary value,
// unipolar (count of ones) or bipolar (2*ones - 2^N, saturated).
module sc_to_bin #(
    parameter int N       = 12,
    parameter bit BIPOLAR = 1'b0
) (
    input  logic         clock_s,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N:0]   out,
    output logic         out_valid,
    output logic         busy
);
    import sc_pkg::*;

    localparam int POW2 = 1 << N;

    state_t      state;
    state_t      state_next;
    logic        clear;
    logic        enable;
    logic        terminal;
    logic [N:0]  ones;
    logic [N:0]  ones_final;

    // 2*ones - 2^N needs N+2 signed bits; only ones == 2^N overflows N+1.
    function automatic logic signed [N:0] encode_bipolar(input logic [N:0] cnt);
        logic signed [N+2:0] twice;
        twice = $signed({1'b0, cnt, 1'b0}) - $signed((N+3)'(POW2));
        if (cnt == (N+1)'(POW2))
            return (N+1)'(POW2 - 1);
        return twice[N:0];
    endfunction

    function automatic logic [N:0] encode(input logic [N:0] cnt);
        if (BIPOLAR)
            return encode_bipolar(cnt);
        return cnt;
    endfunction

    sc_bit_counter #(.N(N)) u_counter (
        .clock_s  (clock_s),
        .reset    (reset),
        .clear    (clear),
        .enable   (enable),
        .bit_in   (bit_in),
        .ones     (ones),
        .terminal (terminal)
    );

    // The closing bit is folded in here so the result lands one edge after it.
    assign ones_final = ones + (N+1)'(bit_in);
    assign busy       = (state == COUNT);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        enable     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COUNT;
                    clear      = 1'b1;
                end
            end
            COUNT: begin
                enable = bit_valid;
                if (terminal)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_s) begin
        if (reset) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= terminal;
            if (terminal)
                out <= encode(ones_final);
        end
    end

endmodule

// File: tb/tb_sc_to_bin.sv
// Directed bench for sc_to_bin: 12-bit unipolar and bipolar instances share
// one stimulus stream; a 3-bit instance covers short windows and edge cases.
module tb_sc_to_bin;

    logic clock_s = 1'b0;
    always #5 clock_s = ~clock_s;

    logic        reset, start, bit_in, bit_valid;
    logic [12:0] out_u, out_b;
    logic        ov_u, ov_b, busy_u, busy_b;

    logic        s_start, s_bit, s_valid;
    logic [3:0]  s_out;
    logic        s_ov, s_busy;

    sc_to_bin #(.N(12), .BIPOLAR(1'b0)) u_uni (
        .clock_s(clock_s), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .out(out_u), .out_valid(ov_u), .busy(busy_u));

    sc_to_bin #(.N(12), .BIPOLAR(1'b1)) u_bip (
        .clock_s(clock_s), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .out(out_b), .out_valid(ov_b), .busy(busy_b));

    sc_to_bin #(.N(3), .BIPOLAR(1'b0)) u_small (
        .clock_s(clock_s), .reset(reset), .start(s_start), .bit_in(s_bit),
        .bit_valid(s_valid), .out(s_out), .out_valid(s_ov), .busy(s_busy));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_ov_cyc = 0;

    always @(posedge clock_s) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_s);
        #1;
    endtask

    // One full 4096-bit window on the 12-bit pair; first k bits are ones.
    task automatic window(input string tag, input int k,
                          input int stall_a, input int len_a,
                          input int stall_b, input int len_b,
                          input bit hold, input logic [12:0] exp_u, input logic [12:0] exp_b);
        int s_cyc;
        int early = 0;
        int busy_drop = 0;
        start = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        tick;
        s_cyc = cyc;
        if (ov_u || ov_b) early++;
        chk({tag, " busy_open"}, 32'(busy_u), 32'd1);
        start = hold;
        for (int i = 0; i < 4096; i++) begin
            if (i == stall_a || i == stall_b) begin
                bit_valid = 1'b0;
                repeat ((i == stall_a) ? len_a : len_b) begin
                    tick;
                    if (ov_u || ov_b) early++;
                    if (!busy_u || !busy_b) busy_drop++;
                end
            end
            bit_valid = 1'b1;
            bit_in    = (i < k);
            tick;
            if (i < 4095) begin
                if (ov_u || ov_b) early++;
                if (!busy_u || !busy_b) busy_drop++;
            end
        end
        bit_valid = 1'b0; bit_in = 1'b0;
        chk({tag, " early_valid"}, 32'(early), 32'd0);
        chk({tag, " busy_drop"}, 32'(busy_drop), 32'd0);
        chk({tag, " ov_uni"}, 32'(ov_u), 32'd1);
        chk({tag, " ov_bip"}, 32'(ov_b), 32'd1);
        chk({tag, " out_uni"}, 32'(out_u), 32'(exp_u));
        chk({tag, " out_bip"}, 32'(out_b), 32'(exp_b));
        chk({tag, " latency"}, 32'(cyc - s_cyc), 32'(4096 + len_a + len_b));
        chk({tag, " busy_done"}, 32'(busy_u), 32'd0);
        last_ov_cyc = cyc;
        if (!hold) begin
            start = 1'b0;
            tick;
            chk({tag, " ov_pulse"}, 32'(ov_u), 32'd0);
            chk({tag, " out_hold"}, 32'(out_u), 32'(exp_u));
        end
    endtask

    initial begin
        int t1;
        int cnt;
        int model;
        logic [7:0] pat;

        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        s_start = 1'b0; s_bit = 1'b0; s_valid = 1'b0;
        repeat (2) tick;
        start = 1'b1;
        tick;
        chk("rst out_uni", 32'(out_u), 32'd0);
        chk("rst out_bip", 32'(out_b), 32'd0);
        chk("rst ov", 32'(ov_u), 32'd0);
        chk("rst busy_prio", 32'(busy_u), 32'd0);
        chk("rst small_out", 32'(s_out), 32'd0);
        reset = 1'b0; start = 1'b0;
        tick;

        window("w1533", 1533, -1, 0, -1, 0, 1'b0, 13'd1533, 13'd7162);
        window("ones",  4096, -1, 0, -1, 0, 1'b0, 13'd4096, 13'd4095);
        window("zeros",    0, -1, 0, -1, 0, 1'b0, 13'd0,    13'h1000);
        window("half",  2048, -1, 0, -1, 0, 1'b0, 13'd2048, 13'd0);
        window("stall", 1533, 700, 37, 3000, 63, 1'b0, 13'd1533, 13'd7162);

        // start held across three consecutive windows
        window("held78", 78, -1, 0, -1, 0, 1'b1, 13'd78, 13'd4252);
        t1 = last_ov_cyc;
        window("held943", 943, -1, 0, -1, 0, 1'b1, 13'd943, 13'd5982);
        chk("held period1", 32'(last_ov_cyc - t1), 32'd4097);
        t1 = last_ov_cyc;
        window("held3", 3, -1, 0, -1, 0, 1'b0, 13'd3, 13'd4102);
        chk("held period2", 32'(last_ov_cyc - t1 - 1), 32'd4097 - 32'd1);

        // reset in the middle of a window
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit_valid = 1'b1; bit_in = i[0];
            tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0; bit_valid = 1'b0;
        chk("midrst ov", 32'(ov_u), 32'd0);
        chk("midrst out_uni", 32'(out_u), 32'd0);
        chk("midrst out_bip", 32'(out_b), 32'd0);
        chk("midrst busy", 32'(busy_u), 32'd0);
        cnt = 0;
        repeat (5) begin
            tick;
            if (ov_u || busy_u) cnt++;
        end
        chk("midrst quiet", 32'(cnt), 32'd0);
        window("after_rst", 943, -1, 0, -1, 0, 1'b0, 13'd943, 13'd5982);

        // N=3: start pulses mid-window must not restart it
        pat = 8'b1011_0110;
        model = 0;
        cnt = 0;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                s_valid = 1'b0; s_start = 1'b1; s_bit = 1'b1;
                tick;
                if (s_ov || !s_busy) cnt++;
            end
            s_start = (i == 5);
            s_valid = 1'b1; s_bit = pat[i];
            if (s_busy) model += int'(pat[i]);
            tick;
            if (i < 7 && (s_ov || !s_busy)) cnt++;
        end
        s_start = 1'b0; s_valid = 1'b1; s_bit = 1'b1;
        chk("n3 window", 32'(cnt), 32'd0);
        chk("n3 ov", 32'(s_ov), 32'd1);
        chk("n3 out_model", 32'(s_out), 32'(model));
        chk("n3 out_hand", 32'(s_out), 32'd5);
        tick;
        tick;
        chk("n3 idle_busy", 32'(s_busy), 32'd0);
        chk("n3 idle_ov", 32'(s_ov), 32'd0);
        chk("n3 idle_hold", 32'(s_out), 32'd5);

        // N=3 all ones: count reaches 2^N
        s_start = 1'b1; s_valid = 1'b0;
        tick;
        s_start = 1'b0;
        repeat (8) begin
            s_valid = 1'b1; s_bit = 1'b1;
            tick;
        end
        s_valid = 1'b0;
        chk("n3 full ov", 32'(s_ov), 32'd1);
        chk("n3 full out", 32'(s_out), 32'd8);

        // reset coinciding with the closing bit wins
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        repeat (7) begin
            s_valid = 1'b1; s_bit = 1'b1;
            tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0; s_valid = 1'b0;
        chk("n3 rstlast ov", 32'(s_ov), 32'd0);
        chk("n3 rstlast out", 32'(s_out), 32'd0);
        chk("n3 rstlast busy", 32'(s_busy), 32'd0);
        tick;
        chk("n3 rstlast late_ov", 32'(s_ov), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_to_bin.md
SC_TO_BIN -- requirements
Module: sc_to_bin

Interface
REQ-001 Parameter N, default 12: stream length is 2^N bits; output is N+1 bits.
REQ-002 Parameter BIPOLAR, default 0: 0 selects unipolar decode, 1 selects bipolar decode.
REQ-003 clock_s  in  1  single clock (sampling/bitstream clock); all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to open a conversion window; sampled only in IDLE.
REQ-006 bit_in  in  1  stochastic bitstream bit.
REQ-007 bit_valid  in  1  qualifies bit_in; bit counts only when high in COUNT.
REQ-008 out  out  N+1  binary result; holds last result until the next result.
REQ-009 out_valid  out  1  one-cycle pulse marking a new value on out.
REQ-010 busy  out  1  high while a conversion window is open (state COUNT).

Function
REQ-011 The state machine SHALL have exactly two states: IDLE and COUNT.
REQ-012 In IDLE with start=1, the next state SHALL be COUNT, with ones counter=0 and seen counter=0.
REQ-013 In COUNT with bit_valid=1, seen SHALL increment by 1 and ones SHALL increment by bit_in.
REQ-014 In COUNT with bit_valid=0, both counters SHALL hold, so the window stalls.
REQ-015 The window SHALL close on the accepted bit that makes seen reach 2^N; that bit is counted.
REQ-016 On the clock edge after that bit, out SHALL update, out_valid SHALL pulse for one cycle, and the state SHALL return to IDLE (latency 1 cycle).
REQ-017 If start=1 during the out_valid cycle (state IDLE), a new window SHALL open, so back-to-back windows have a 1-cycle gap.
REQ-018 start in COUNT SHALL be ignored and SHALL NOT restart or extend the window.
REQ-019 The ones counter SHALL be N+1 bits, range 0..2^N inclusive; the seen counter SHALL be N+1 bits.
REQ-020 Unipolar (BIPOLAR=0): out SHALL equal ones as unsigned (0..2^N).
REQ-021 Bipolar (BIPOLAR=1): out SHALL equal 2*ones-2^N in two's complement N+1 bits.
REQ-022 Bipolar saturation: when ones=2^N, out SHALL be 2^N-1 (+4095 for N=12); when ones=0, out SHALL be -2^N (0x1000).
REQ-023 The out value SHALL NOT change except on an out_valid cycle or on reset.
REQ-024 busy SHALL be 1 exactly in COUNT.

Reset
REQ-025 When reset=1 at a clock edge, the next state SHALL be IDLE, out=0, out_valid=0, busy=0, and both counters=0.
REQ-026 Reset mid-window SHALL discard the partial count with no out_valid.
REQ-027 Reset SHALL take priority over start, bit_valid and window completion in the same cycle.

Structure
REQ-028 Package sc_pkg SHALL hold N, POW2N (=2^N), the state enum (IDLE, COUNT) and the bipolar saturation constants.
REQ-029 The ones/seen counting SHALL be a single sub-module, sc_bit_counter (clear, enable, bit; outputs ones and a terminal flag).
REQ-030 The encoding arithmetic and the FSM SHALL stay in sc_to_bin.

Verification
REQ-031 N=12, BIPOLAR=0, start, then 4096 valid bits with exactly 1533 ones -> out=1533, out_valid high for 1 cycle 1 cycle after the last bit, busy low afterward.
REQ-032 N=12, BIPOLAR=1, all-ones stream -> out=4095 (saturated); all-zeros stream -> out=0x1000 (-4096); 2048 ones -> out=0.
REQ-033 Same as REQ-031 but with bit_valid deasserted for 100 cycles at random points -> same out=1533; out_valid delayed by exactly 100 cycles.
REQ-034 start held continuously, 3 windows with 78, 943 and 3 ones -> results 78, 943, 3 in order, each window 4097 cycles apart, and no start accepted while busy.
REQ-035 reset asserted after 2000 bits, then a new full window with 943 ones -> no out_valid at the reset, out=0 after reset, then out=943.
REQ-036 N=3 (stream of 8 bits), start pulsed mid-window -> window length stays 8 accepted bits; the result matches the reference count model.
